vga_scanner: RTL and testbench

//  Raster timing source and pixel output stage for the layer pipeline.
//  - Walks the VGA beam and broadcasts signed paint_x/paint_y and new_frame to every layer.
//  - Owns the per-frame scroll counter, exported as shift.
//  - Registers the composited pixel_color/pixel_valid onto the VGA pins, with sync and DE aligned to it.
//  - Layers compensate their own pipeline depth: the colour they return at cycle t belongs to paint_x/paint_y of cycle t.

---
 rtl/vga_scanner.sv | 158 +++++++++++++++
 tb/tb_vga_scanner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanner.sv
// VGA raster timing source and registered pixel output stage.
// Broadcasts the signed paint position, new_frame and the per-frame scroll shift to the layers.
module vga_scanner #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FRONT     = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BACK      = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FRONT     = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BACK      = 33,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int          SHIFT_WRAP  = 28,
    parameter int          SCROLL_STEP = 1,
    parameter logic [15:0] BG_COLOR    = 16'h0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_scroll_en,
    input  logic        i_pixel_valid,
    input  logic [15:0] i_pixel_color,
    output logic [15:0] o_paint_x,
    output logic [15:0] o_paint_y,
    output logic        o_new_frame,
    output logic [15:0] o_shift,
    output logic        o_vga_hsync,
    output logic        o_vga_vsync,
    output logic        o_vga_de,
    output logic [3:0]  o_vga_r,
    output logic [3:0]  o_vga_g,
    output logic [3:0]  o_vga_b
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [3:0] BG_R = BG_COLOR[15:12];
    localparam logic [3:0] BG_G = BG_COLOR[10:7];
    localparam logic [3:0] BG_B = BG_COLOR[4:1];

    logic [15:0] r_h_cnt;
    logic [15:0] r_v_cnt;
    // Counter values of the position currently on paint_x/paint_y.
    logic [15:0] r_h_d;
    logic [15:0] r_v_d;
    // Low on the first cycle after reset, when paint_x/paint_y still hold reset values, not a scanned position.
    logic        r_run;

    logic [15:0] r_paint_x;
    logic [15:0] r_paint_y;
    logic        r_new_frame;
    logic [15:0] r_shift;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [3:0]  r_r;
    logic [3:0]  r_g;
    logic [3:0]  r_b;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_start;
    logic [15:0] w_paint_x;
    logic [15:0] w_paint_y;
    logic [16:0] w_shift_sum;
    logic [15:0] w_shift_next;
    logic        w_p_active;
    logic        w_p_hsync;
    logic        w_p_vsync;
    logic        w_unused_bits;

    assign w_h_last      = (r_h_cnt == 16'(H_TOTAL - 1));
    assign w_v_last      = (r_v_cnt == 16'(V_TOTAL - 1));
    assign w_frame_start = (r_h_cnt == 16'd0) && (r_v_cnt == 16'(V_ACTIVE));

    assign w_paint_x = (r_h_cnt < 16'(H_ACTIVE)) ? r_h_cnt : r_h_cnt - 16'(H_TOTAL);
    assign w_paint_y = (r_v_cnt < 16'(V_ACTIVE)) ? r_v_cnt : r_v_cnt - 16'(V_TOTAL);

    assign w_shift_sum  = {1'b0, r_shift} + 17'(SCROLL_STEP);
    assign w_shift_next = (w_shift_sum >= 17'(SHIFT_WRAP)) ? 16'(w_shift_sum - 17'(SHIFT_WRAP))
                                                         : w_shift_sum[15:0];

    assign w_p_active = r_run && (r_h_d < 16'(H_ACTIVE)) && (r_v_d < 16'(V_ACTIVE));
    assign w_p_hsync  = (r_h_d >= 16'(HS_START)) && (r_h_d < 16'(HS_END));
    assign w_p_vsync  = (r_v_d >= 16'(VS_START)) && (r_v_d < 16'(VS_END));

    // RGB565 LSBs dropped in the RGB444 conversion.
    assign w_unused_bits = ^{i_pixel_color[11], i_pixel_color[6:5], i_pixel_color[0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_last ? 16'd0 : r_h_cnt + 16'd1;
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? 16'd0 : r_v_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_h_d       <= '0;
            r_v_d       <= '0;
            r_run       <= 1'b0;
            r_paint_x   <= '0;
            r_paint_y   <= '0;
            r_new_frame <= 1'b0;
            r_shift     <= '0;
        end else begin
            r_h_d       <= r_h_cnt;
            r_v_d       <= r_v_cnt;
            r_run       <= 1'b1;
            r_paint_x   <= w_paint_x;
            r_paint_y   <= w_paint_y;
            r_new_frame <= w_frame_start;
            if (w_frame_start && i_scroll_en) begin
                r_shift <= w_shift_next;
            end
        end
    end

    // Output stage: everything here describes the position that was on paint_x/paint_y last cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_de    <= 1'b0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
        end else begin
            r_hsync <= w_p_hsync ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_p_vsync ? SYNC_POL : ~SYNC_POL;
            r_de    <= w_p_active;
            r_r     <= w_p_active ? (i_pixel_valid ? i_pixel_color[15:12] : BG_R) : 4'd0;
            r_g     <= w_p_active ? (i_pixel_valid ? i_pixel_color[10:7]  : BG_G) : 4'd0;
            r_b     <= w_p_active ? (i_pixel_valid ? i_pixel_color[4:1]   : BG_B) : 4'd0;
        end
    end

    assign o_paint_x   = r_paint_x;
    assign o_paint_y   = r_paint_y;
    assign o_new_frame = r_new_frame;
    assign o_shift     = r_shift;
    assign o_vga_hsync = r_hsync;
    assign o_vga_vsync = r_vsync;
    assign o_vga_de    = r_de;
    assign o_vga_r     = r_r;
    assign o_vga_g     = r_g;
    assign o_vga_b     = r_b;

endmodule

// File: tb/tb_vga_scanner.sv
// Directed bench for vga_scanner on a shrunken raster (15x11 clocks per frame) so whole frames stay short.
module tb_vga_scanner;

    localparam int HA  = 8;
    localparam int HT  = 15;
    localparam int VA  = 6;
    localparam int VT  = 11;
    localparam int FT  = HT * VT;
    localparam int HS0 = 10;
    localparam int HS1 = 13;
    localparam int VS0 = 7;
    localparam int VS1 = 9;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        scroll_en = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [15:0] pixel_color = 16'h0000;

    logic [15:0] paint_x;
    logic [15:0] paint_y;
    logic        new_frame;
    logic [15:0] shift;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_de;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vga_scanner #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b0), .SHIFT_WRAP(28), .SCROLL_STEP(3), .BG_COLOR(16'h1234)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_scroll_en(scroll_en),
        .i_pixel_valid(pixel_valid),
        .i_pixel_color(pixel_color),
        .o_paint_x(paint_x),
        .o_paint_y(paint_y),
        .o_new_frame(new_frame),
        .o_shift(shift),
        .o_vga_hsync(vga_hsync),
        .o_vga_vsync(vga_vsync),
        .o_vga_de(vga_de),
        .o_vga_r(vga_r),
        .o_vga_g(vga_g),
        .o_vga_b(vga_b)
    );

    // cyc counts negedges since reset release; at cyc the paint position is scan index cyc.
    function automatic logic [15:0] exp_px(input int c);
        int h;
        h = c % HT;
        return (h < HA) ? 16'(h) : 16'(h - HT);
    endfunction

    function automatic logic [15:0] exp_py(input int c);
        int v;
        v = (c / HT) % VT;
        return (v < VA) ? 16'(v) : 16'(v - VT);
    endfunction

    function automatic logic exp_nf(input int c);
        return ((c % HT) == 0) && (((c / HT) % VT) == VA);
    endfunction

    // The output pins at cyc describe scan index cyc-1.
    function automatic logic out_act(input int c);
        if (c < 1) return 1'b0;
        return (((c - 1) % HT) < HA) && ((((c - 1) / HT) % VT) < VA);
    endfunction

    function automatic logic exp_hs(input int c);
        int h;
        if (c < 1) return 1'b1;
        h = (c - 1) % HT;
        return !((h >= HS0) && (h < HS1));
    endfunction

    function automatic logic exp_vs(input int c);
        int v;
        if (c < 1) return 1'b1;
        v = ((c - 1) / HT) % VT;
        return !((v >= VS0) && (v < VS1));
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (paint_x !== 16'd0) begin errors++; $display("FAIL reset_paint_x got=%0d exp=0", paint_x); end
        checks++; if (paint_y !== 16'd0) begin errors++; $display("FAIL reset_paint_y got=%0d exp=0", paint_y); end
        checks++; if (new_frame !== 1'b0) begin errors++; $display("FAIL reset_new_frame got=%b exp=0", new_frame); end
        checks++; if (shift !== 16'd0) begin errors++; $display("FAIL reset_shift got=%0d exp=0", shift); end
        checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL reset_de got=%b exp=0", vga_de); end
        checks++; if ({vga_hsync, vga_vsync} !== 2'b11) begin errors++; $display("FAIL reset_sync got=%b exp=11", {vga_hsync, vga_vsync}); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", {vga_r, vga_g, vga_b}); end
        rstn = 1'b1;
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic test_frame();
        int de_cnt = 0;
        int nf_cnt = 0;
        int nf_at = -1;
        for (int i = 0; i < FT; i++) begin
            checks++; if (paint_x !== exp_px(cyc)) begin errors++; $display("FAIL frame_paint_x cyc=%0d got=%0d exp=%0d", cyc, $signed(paint_x), $signed(exp_px(cyc))); end
            checks++; if (paint_y !== exp_py(cyc)) begin errors++; $display("FAIL frame_paint_y cyc=%0d got=%0d exp=%0d", cyc, $signed(paint_y), $signed(exp_py(cyc))); end
            checks++; if (vga_de !== out_act(cyc)) begin errors++; $display("FAIL frame_de cyc=%0d got=%b exp=%b", cyc, vga_de, out_act(cyc)); end
            checks++; if (new_frame !== exp_nf(cyc)) begin errors++; $display("FAIL frame_new_frame cyc=%0d got=%b exp=%b", cyc, new_frame, exp_nf(cyc)); end
            if (vga_de === 1'b1) de_cnt++;
            if (new_frame === 1'b1) begin nf_cnt++; nf_at = cyc; end
            next_cycle();
        end
        checks++; if (de_cnt != HA * VA) begin errors++; $display("FAIL frame_de_count got=%0d exp=%0d", de_cnt, HA * VA); end
        checks++; if (nf_cnt != 1) begin errors++; $display("FAIL frame_nf_count got=%0d exp=1", nf_cnt); end
        checks++; if (nf_at != VA * HT) begin errors++; $display("FAIL frame_nf_cycle got=%0d exp=%0d", nf_at, VA * HT); end
    endtask

    task automatic test_line_sweep();
        int hs_low = 0;
        for (int i = 0; i < FT; i++) begin
            checks++; if (paint_x !== exp_px(cyc)) begin errors++; $display("FAIL sweep_paint_x cyc=%0d got=%0d exp=%0d", cyc, $signed(paint_x), $signed(exp_px(cyc))); end
            checks++; if (vga_hsync !== exp_hs(cyc)) begin errors++; $display("FAIL sweep_hsync cyc=%0d got=%b exp=%b", cyc, vga_hsync, exp_hs(cyc)); end
            checks++; if (vga_vsync !== exp_vs(cyc)) begin errors++; $display("FAIL sweep_vsync cyc=%0d got=%b exp=%b", cyc, vga_vsync, exp_vs(cyc)); end
            if (vga_hsync === 1'b0) hs_low++;
            next_cycle();
        end
        checks++; if (hs_low != 3 * VT) begin errors++; $display("FAIL sweep_hsync_low_count got=%0d exp=%0d", hs_low, 3 * VT); end
    endtask

    task automatic test_scroll();
        logic [15:0] tab [11] = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd15, 16'd18, 16'd21, 16'd24, 16'd27, 16'd2, 16'd5};
        logic [15:0] cur = 16'd0;
        int idx = 0;
        int budget = 0;
        int nf_cnt = 0;
        scroll_en = 1'b1;
        while (idx < 11 && budget < 12 * FT) begin
            if (new_frame === 1'b1) begin
                checks++; if (shift !== tab[idx]) begin errors++; $display("FAIL scroll_step%0d got=%0d exp=%0d", idx, shift, tab[idx]); end
                cur = tab[idx];
                idx++;
            end else begin
                checks++; if (shift !== cur) begin errors++; $display("FAIL scroll_hold cyc=%0d got=%0d exp=%0d", cyc, shift, cur); end
            end
            next_cycle();
            budget++;
        end
        checks++; if (idx != 11) begin errors++; $display("FAIL scroll_timeout frames got=%0d exp=11", idx); end
        scroll_en = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            checks++; if (shift !== 16'd5) begin errors++; $display("FAIL scroll_frozen cyc=%0d got=%0d exp=5", cyc, shift); end
            if (new_frame === 1'b1) nf_cnt++;
            next_cycle();
        end
        checks++; if (nf_cnt != 2) begin errors++; $display("FAIL scroll_frozen_frames got=%0d exp=2", nf_cnt); end
    endtask

    task automatic test_rgb();
        logic prev_v;
        logic [11:0] exp_rgb;
        pixel_color = 16'hF81F;
        pixel_valid = 1'b0;
        next_cycle();
        prev_v = pixel_valid;
        for (int i = 0; i < FT; i++) begin
            if (!out_act(cyc)) exp_rgb = 12'h000;
            else if (prev_v)   exp_rgb = 12'hF0F;
            else               exp_rgb = 12'h14A;
            checks++; if ({vga_r, vga_g, vga_b} !== exp_rgb) begin errors++; $display("FAIL rgb_toggle cyc=%0d got=%h exp=%h", cyc, {vga_r, vga_g, vga_b}, exp_rgb); end
            pixel_valid = ~pixel_valid;
            prev_v = pixel_valid;
            next_cycle();
        end
    endtask

    task automatic test_blank();
        logic [11:0] exp_rgb;
        int blank_seen = 0;
        pixel_color = 16'hFFFF;
        pixel_valid = 1'b1;
        next_cycle();
        for (int i = 0; i < FT; i++) begin
            exp_rgb = out_act(cyc) ? 12'hFFF : 12'h000;
            if (!out_act(cyc)) blank_seen++;
            checks++; if ({vga_r, vga_g, vga_b} !== exp_rgb) begin errors++; $display("FAIL rgb_blank cyc=%0d got=%h exp=%h", cyc, {vga_r, vga_g, vga_b}, exp_rgb); end
            next_cycle();
        end
        checks++; if (blank_seen != FT - HA * VA) begin errors++; $display("FAIL rgb_blank_cycles got=%0d exp=%0d", blank_seen, FT - HA * VA); end
    endtask

    task automatic test_reset_mid();
        int budget = 0;
        while (!((cyc % HT) == 3 && ((cyc / HT) % VT) == 2) && budget < FT) begin
            next_cycle();
            budget++;
        end
        checks++; if (paint_x !== 16'd3 || paint_y !== 16'd2) begin errors++; $display("FAIL midreset_position got=%0d,%0d exp=3,2", paint_x, paint_y); end
        checks++; if (shift !== 16'd5) begin errors++; $display("FAIL midreset_shift_before got=%0d exp=5", shift); end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (paint_x !== 16'd0 || paint_y !== 16'd0) begin errors++; $display("FAIL midreset_paint got=%0d,%0d exp=0,0", paint_x, paint_y); end
        checks++; if (shift !== 16'd0) begin errors++; $display("FAIL midreset_shift got=%0d exp=0", shift); end
        checks++; if (vga_de !== 1'b0 || new_frame !== 1'b0) begin errors++; $display("FAIL midreset_de_nf got=%b%b exp=00", vga_de, new_frame); end
        checks++; if ({vga_hsync, vga_vsync} !== 2'b11) begin errors++; $display("FAIL midreset_sync got=%b exp=11", {vga_hsync, vga_vsync}); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++; $display("FAIL midreset_rgb got=%h exp=000", {vga_r, vga_g, vga_b}); end
        rstn = 1'b1;
        @(negedge clk);
        cyc = 0;
        for (int i = 0; i < FT; i++) begin
            checks++; if (paint_x !== exp_px(cyc) || paint_y !== exp_py(cyc)) begin errors++; $display("FAIL resume_paint cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc, $signed(paint_x), $signed(paint_y), $signed(exp_px(cyc)), $signed(exp_py(cyc))); end
            checks++; if (new_frame !== exp_nf(cyc)) begin errors++; $display("FAIL resume_new_frame cyc=%0d got=%b exp=%b", cyc, new_frame, exp_nf(cyc)); end
            checks++; if (shift !== 16'd0) begin errors++; $display("FAIL resume_shift cyc=%0d got=%0d exp=0", cyc, shift); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_line_sweep();
        test_scroll();
        test_rgb();
        test_blank();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
